// File: rtl/sddt_rdata_packetizer.sv
// Read-data framer: groups SDDT read beats into PKT_BEATS-beat AXI-Stream packets, closing partial packets on flush.
// Optional idle-timeout close is built in when RDATA_TIMEOUT_EN is defined.
module sddt_rdata_packetizer #(
    parameter int DATA_W         = 512,
    parameter int PKT_BEATS      = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                  c0_ddr4_clk,
    input  logic                  c0_ddr4_rst,
    input  logic [DATA_W-1:0]     s_axis_rdata_tdata,
    input  logic                  s_axis_rdata_tvalid,
    output logic                  s_axis_rdata_tready,
    output logic [DATA_W-1:0]     m_axis_rdata_tdata,
    output logic [DATA_W/8-1:0]   m_axis_rdata_tkeep,
    output logic                  m_axis_rdata_tlast,
    output logic                  m_axis_rdata_tvalid,
    input  logic                  m_axis_rdata_tready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      beat_count,
    output logic [CNT_W-1:0]      pkt_count
);

    localparam int IDX_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BEATS - 1);

    // Hold register H
    logic                 h_valid_reg, h_valid_next;
    logic [DATA_W-1:0]    h_data_reg, h_data_next;
    logic                 h_final_reg, h_final_next;

    // Output register O
    logic                 o_valid_reg, o_valid_next;
    logic [DATA_W-1:0]    o_data_reg, o_data_next;
    logic                 o_last_reg, o_last_next;

    logic [IDX_W-1:0]     beat_idx_reg, beat_idx_next;
    logic                 flush_pending_reg, flush_pending_next;
    logic [CNT_W-1:0]     beat_count_reg, beat_count_next;
    logic [CNT_W-1:0]     pkt_count_reg, pkt_count_next;

    logic                 o_free;
    logic                 s_ready;
    logic                 s_fire;
    logic                 timeout_hit;
    logic                 pkt_close;
    logic                 close_fire;
    logic                 move;
    logic                 pkt_done;
    logic [IDX_W-1:0]     idx_base;
    logic                 beat_is_final;

    assign o_free     = !o_valid_reg || m_axis_rdata_tready;
    assign s_ready    = !c0_ddr4_rst && !flush_pending_reg && (!h_valid_reg || o_free);
    assign s_fire     = s_axis_rdata_tvalid && s_ready;
    assign pkt_close  = h_valid_reg && !h_final_reg && (flush_pending_reg || timeout_hit);
    // A close only takes effect once O can accept the closing beat; until then the request persists.
    assign close_fire = pkt_close && o_free;
    assign move       = h_valid_reg && o_free && (h_final_reg || pkt_close || s_fire);
    assign pkt_done   = o_valid_reg && m_axis_rdata_tready && o_last_reg;

    // A beat accepted alongside a close starts the next packet at index 0.
    assign idx_base      = close_fire ? '0 : beat_idx_reg;
    assign beat_is_final = (idx_base == LAST_IDX);

`ifdef RDATA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt_reg, idle_cnt_next;

    assign timeout_hit = (idle_cnt_reg == TO_LIMIT);

    // Once hit, the count holds until the close actually moves the beat out of H.
    always_comb begin
        idle_cnt_next = '0;
        if (close_fire) begin
            idle_cnt_next = '0;
        end else if (timeout_hit) begin
            idle_cnt_next = idle_cnt_reg;
        end else if (h_valid_reg && !h_final_reg && !s_axis_rdata_tvalid) begin
            idle_cnt_next = idle_cnt_reg + TO_W'(1);
        end
    end

    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`else
    // Without the idle timer, partial packets close only on flush.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        h_valid_next = h_valid_reg;
        h_data_next  = h_data_reg;
        h_final_next = h_final_reg;
        if (s_fire) begin
            h_valid_next = 1'b1;
            h_data_next  = s_axis_rdata_tdata;
            h_final_next = beat_is_final;
        end else if (move) begin
            h_valid_next = 1'b0;
            h_final_next = 1'b0;
        end
    end

    always_comb begin
        o_valid_next = o_valid_reg;
        o_data_next  = o_data_reg;
        o_last_next  = o_last_reg;
        if (move) begin
            o_valid_next = 1'b1;
            o_data_next  = h_data_reg;
            o_last_next  = h_final_reg || pkt_close;
        end else if (o_free) begin
            o_valid_next = 1'b0;
        end
    end

    always_comb begin
        beat_idx_next = idx_base;
        if (s_fire) begin
            beat_idx_next = beat_is_final ? '0 : idx_base + IDX_W'(1);
        end
    end

    // The pending flush blocks the input, so no new beat can slip into the closing packet.
    always_comb begin
        flush_pending_next = flush_pending_reg;
        if (flush && h_valid_reg && !h_final_reg) begin
            flush_pending_next = 1'b1;
        end else if (!h_valid_reg) begin
            flush_pending_next = 1'b0;
        end
    end

    always_comb begin
        beat_count_next = beat_count_reg;
        pkt_count_next  = pkt_count_reg;
        if (s_fire) begin
            beat_count_next = beat_count_reg + CNT_W'(1);
        end
        if (pkt_done) begin
            pkt_count_next = pkt_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            h_valid_reg       <= 1'b0;
            h_data_reg        <= '0;
            h_final_reg       <= 1'b0;
            o_valid_reg       <= 1'b0;
            o_data_reg        <= '0;
            o_last_reg        <= 1'b0;
            beat_idx_reg      <= '0;
            flush_pending_reg <= 1'b0;
            beat_count_reg    <= '0;
            pkt_count_reg     <= '0;
        end else begin
            h_valid_reg       <= h_valid_next;
            h_data_reg        <= h_data_next;
            h_final_reg       <= h_final_next;
            o_valid_reg       <= o_valid_next;
            o_data_reg        <= o_data_next;
            o_last_reg        <= o_last_next;
            beat_idx_reg      <= beat_idx_next;
            flush_pending_reg <= flush_pending_next;
            beat_count_reg    <= beat_count_next;
            pkt_count_reg     <= pkt_count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_keep
            assign m_axis_rdata_tkeep[gi] = 1'b1;
        end
    endgenerate

    assign s_axis_rdata_tready = s_ready;
    assign m_axis_rdata_tvalid = o_valid_reg;
    assign m_axis_rdata_tdata  = o_data_reg;
    assign m_axis_rdata_tlast  = o_last_reg;
    assign beat_count          = beat_count_reg;
    assign pkt_count           = pkt_count_reg;

endmodule

// File: tb/tb_sddt_rdata_packetizer.sv
// Bench for sddt_rdata_packetizer: directed steps plus random traffic against a queue-based packet model.
// Honours RDATA_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_sddt_rdata_packetizer;

    localparam int DATA_W         = 64;
    localparam int PKT_BEATS      = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_W-1:0]    s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_W-1:0]    m_tdata;
    logic [DATA_W/8-1:0]  m_tkeep;
    logic                 m_tlast;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 flush;
    logic [CNT_W-1:0]     beat_count;
    logic [CNT_W-1:0]     pkt_count;

    always #5 clk = ~clk;

    sddt_rdata_packetizer #(
        .DATA_W         (DATA_W),
        .PKT_BEATS      (PKT_BEATS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .c0_ddr4_clk         (clk),
        .c0_ddr4_rst         (rst),
        .s_axis_rdata_tdata  (s_data),
        .s_axis_rdata_tvalid (s_valid),
        .s_axis_rdata_tready (s_ready),
        .m_axis_rdata_tdata  (m_tdata),
        .m_axis_rdata_tkeep  (m_tkeep),
        .m_axis_rdata_tlast  (m_tlast),
        .m_axis_rdata_tvalid (m_tvalid),
        .m_axis_rdata_tready (m_tready),
        .flush               (flush),
        .beat_count          (beat_count),
        .pkt_count           (pkt_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: accepted beats in order, each tagged with whether it ends a packet.
    logic [DATA_W-1:0] exp_data[$];
    bit                exp_last[$];
    int                pos_model   = 0;
    int                idle_model  = 0;
    int                pkt_total   = 0;
    int                out_total   = 0;
    int                cyc         = 0;
    int                acc_cyc     = 0;
    int                last_out_cyc = 0;
    bit                acc_flag    = 1'b0;
    bit                prev_stall  = 1'b0;
    logic [DATA_W-1:0] prev_data   = '0;
    logic              prev_last   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic close_model();
        exp_last[exp_last.size() - 1] = 1'b1;
        pos_model  = 0;
        idle_model = 0;
    endtask

    // One clock: observe at the falling edge, update the model, then return just after the rising edge.
    task automatic tick();
        logic [DATA_W-1:0] d;
        bit                l;
        @(negedge clk);
        acc_flag = 1'b0;
        if (rst) begin
            exp_data.delete();
            exp_last.delete();
            pos_model  = 0;
            idle_model = 0;
            pkt_total  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_data", m_tdata, prev_data);
                check("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                out_total++;
                last_out_cyc = cyc;
                vectors++;
                assert (exp_data.size() != 0) else begin
                    miscompares++;
                    $error("FAIL spurious_out: observed data %0h with no beat expected", m_tdata);
                end
                if (exp_data.size() != 0) begin
                    d = exp_data.pop_front();
                    l = exp_last.pop_front();
                    check("out_data", m_tdata, d);
                    check("out_last", 64'(m_tlast), 64'(l));
                    if (l) pkt_total++;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
`ifdef RDATA_TIMEOUT_EN
            if (pos_model != 0 && !s_valid) begin
                idle_model++;
                if (idle_model >= TIMEOUT_CYCLES) close_model();
            end else begin
                idle_model = 0;
            end
`endif
            if (flush && pos_model != 0) close_model();
            if (s_valid && s_ready) begin
                acc_flag = 1'b1;
                acc_cyc  = cyc;
                exp_data.push_back(s_data);
                exp_last.push_back(pos_model == PKT_BEATS - 1);
                pos_model = (pos_model == PKT_BEATS - 1) ? 0 : pos_model + 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, output int waited);
        s_valid = 1'b1;
        s_data  = d;
        waited  = 0;
        do begin
            tick();
            waited++;
        end while (!acc_flag && waited < 100);
        check("send_accepted", 64'(acc_flag), 64'd1);
    endtask

    task automatic drain();
        int n;
        n        = 0;
        s_valid  = 1'b0;
        m_tready = 1'b1;
        while ((exp_data.size() != 0 || m_tvalid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(exp_data.size()), 64'd0);
    endtask

    initial begin
        int w;
        int base_out;
        int acc2;
        int sent;
        int n;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_tready = 1'b0; flush = 1'b0;
        tick();
        tick();
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_tready", 64'(s_ready), 64'd0);
        check("tkeep", 64'(m_tkeep), 64'hFF);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(s_ready), 64'd1);

        // Back-to-back beats, sink always ready
        m_tready = 1'b1;
        base_out = out_total;
        for (int i = 0; i < 8; i++) begin
            send_beat(64'hA000 + 64'(i), w);
            check("b2b_no_bubble", 64'(w), 64'd1);
        end
        drain();
        check("b2b_out_beats", 64'(out_total - base_out), 64'd8);
        check("b2b_beat_count", 64'(beat_count), 64'd8);
        check("b2b_pkt_count", 64'(pkt_count), 64'd2);

        // Partial packet closed by flush
        base_out = out_total;
        for (int i = 0; i < 3; i++) send_beat(64'hB000 + 64'(i), w);
        s_valid = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready_low1", 64'(s_ready), 64'd0);
        tick();
        check("flush_ready_low2", 64'(s_ready), 64'd0);
        tick();
        check("flush_ready_back", 64'(s_ready), 64'd1);
        drain();
        check("flush_out_beats", 64'(out_total - base_out), 64'd3);
        check("flush_pkt_count", 64'(pkt_count), 64'd3);
        base_out = out_total;
        for (int i = 0; i < 4; i++) send_beat(64'hB100 + 64'(i), w);
        drain();
        check("post_flush_out_beats", 64'(out_total - base_out), 64'd4);
        check("post_flush_pkt_count", 64'(pkt_count), 64'd4);
        check("post_flush_beat_count", 64'(beat_count), 64'd15);

        // Two beats then idle
        base_out = out_total;
        send_beat(64'hC000, w);
        send_beat(64'hC001, w);
        acc2    = acc_cyc;
        s_valid = 1'b0;
`ifdef RDATA_TIMEOUT_EN
        n = 0;
        while ((out_total - base_out) < 2 && n < 40) begin
            tick();
            n++;
        end
        check("timeout_out_beats", 64'(out_total - base_out), 64'd2);
        check("timeout_latency_ok", 64'((last_out_cyc - acc2) <= 18), 64'd1);
        drain();
`else
        repeat (40) tick();
        check("idle_out_beats", 64'(out_total - base_out), 64'd1);
        check("idle_tvalid", 64'(m_tvalid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();
        check("idle_flush_out_beats", 64'(out_total - base_out), 64'd2);
`endif
        check("idle_pkt_count", 64'(pkt_count), 64'd5);
        check("idle_beat_count", 64'(beat_count), 64'd17);

        // Random traffic with 50% sink stalls
        sent    = 0;
        n       = 0;
        s_valid = 1'b0;
        while (sent < 1000 && n < 20000) begin
            if (!s_valid && $urandom_range(3) != 0) begin
                s_valid = 1'b1;
                s_data  = {$urandom, $urandom};
            end
            m_tready = 1'($urandom_range(1));
            tick();
            n++;
            if (acc_flag) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        check("rand_sent", 64'(sent), 64'd1000);
        drain();
        check("rand_beat_count", 64'(beat_count), 64'd1017);
        check("rand_pkt_count", 64'(pkt_count), 64'(pkt_total[CNT_W-1:0]));

        // Reset with H and O both occupied
        m_tready = 1'b0;
        send_beat(64'hD000, w);
        send_beat(64'hD001, w);
        s_valid = 1'b0;
        tick();
        check("full_tvalid", 64'(m_tvalid), 64'd1);
        check("full_tready", 64'(s_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_tlast", 64'(m_tlast), 64'd0);
        check("midrst_beat_count", 64'(beat_count), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        m_tready = 1'b1;
        base_out = out_total;
        for (int i = 0; i < 4; i++) send_beat(64'hE000 + 64'(i), w);
        drain();
        check("midrst_out_beats", 64'(out_total - base_out), 64'd4);
        check("midrst_one_pkt", 64'(pkt_count), 64'd1);
        check("midrst_beats", 64'(beat_count), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
